// File: rtl/error_channel.sv
// error_channel: injects a burst error pattern into a codeword.
// A request captured in IDLE builds an error mask one bit per cycle in GEN,
// then publishes data XOR mask together with the mask itself in APPLY, and
// pulses done for one cycle in DONE.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   start              - request, sampled only in IDLE
//   data_in            - codeword to corrupt
//   mode               - 0 pass-through, 1 fixed burst, 2 random burst, 3 as 0
//   burst_len          - fixed-mode burst length (clamped to EL)
//   burst_pos          - fixed-mode burst LSB position
//   data_out           - corrupted codeword
//   error_mask         - applied error pattern
//   done               - one-cycle completion pulse
module error_channel #(
    parameter int unsigned N    = 64,
    parameter int unsigned EL   = 10,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [N-1:0]         data_in,
    input  logic [1:0]           mode,
    input  logic [3:0]           burst_len,
    input  logic [$clog2(N)-1:0] burst_pos,
    output logic [N-1:0]         data_out,
    output logic [N-1:0]         error_mask,
    output logic                 done
);

    localparam int unsigned PW = $clog2(N);
    localparam int unsigned CW = $clog2(EL + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GEN   = 2'd1,
        APPLY = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic [N-1:0]   data_q, data_d;
    logic [N-1:0]   mask_q, mask_d;
    logic [N-1:0]   dout_q, dout_d;
    logic [N-1:0]   emask_q, emask_d;
    logic           done_q, done_d;
    logic [CW-1:0]  len_q, len_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  pos_q, pos_d;
    logic           rnd_q, rnd_d;

    // Effective burst length/position for a request accepted this cycle
    logic [CW-1:0]  acc_len_c;
    logic [PW-1:0]  acc_pos_c;
    logic [31:0]    idx_c;
    logic           bit_c;

    always_comb begin
        acc_len_c = '0;
        acc_pos_c = '0;
        case (mode)
            2'd1: begin
                acc_len_c = (32'(burst_len) < EL) ? CW'(burst_len) : CW'(EL);
                acc_pos_c = burst_pos;
            end
            2'd2: begin
                acc_len_c = CW'((32'(lfsr_q[11:8]) % EL) + 32'd1);
                acc_pos_c = PW'(32'(lfsr_q[PW-1:0]) % N);
            end
            default: begin
                acc_len_c = '0;
                acc_pos_c = '0;
            end
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        lfsr_d  = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        data_d  = data_q;
        mask_d  = mask_q;
        dout_d  = dout_q;
        emask_d = emask_q;
        done_d  = 1'b0;
        len_d   = len_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        rnd_d   = rnd_q;
        idx_c   = 32'(pos_q) + 32'(cnt_q);
        // Random bursts force both end bits so the span is always visible
        bit_c   = !rnd_q || (cnt_q == '0) || (cnt_q == len_q - CW'(1)) || lfsr_q[0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    data_d  = data_in;
                    rnd_d   = (mode == 2'd2);
                    len_d   = acc_len_c;
                    pos_d   = acc_pos_c;
                    cnt_d   = '0;
                    mask_d  = '0;
                    state_d = GEN;
                end
            end
            GEN: begin
                if (cnt_q < len_q) begin
                    // Bits beyond the top of the codeword are dropped, not wrapped
                    if (idx_c < N) begin
                        mask_d[idx_c[PW-1:0]] = bit_c;
                    end
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                dout_d  = data_q ^ mask_q;
                emask_d = mask_q;
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            data_q  <= '0;
            mask_q  <= '0;
            dout_q  <= '0;
            emask_q <= '0;
            done_q  <= 1'b0;
            len_q   <= '0;
            cnt_q   <= '0;
            pos_q   <= '0;
            rnd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            dout_q  <= dout_d;
            emask_q <= emask_d;
            done_q  <= done_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            rnd_q   <= rnd_d;
        end
    end

    assign data_out   = dout_q;
    assign error_mask = emask_q;
    assign done       = done_q;

endmodule
